// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: tracks in-flight GPR writers and HI/LO busy time,
// and drives the D-stage stall and forward-source selects.
module hazard_scoreboard #(
  parameter int STAGES   = 3,
  parameter int RA_W     = 5,
  parameter int T_W      = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10,
  parameter int FS_W     = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            d_valid,
  input  logic [RA_W-1:0] d_rs,
  input  logic [RA_W-1:0] d_rt,
  input  logic [T_W-1:0]  d_tuse_rs,
  input  logic [T_W-1:0]  d_tuse_rt,
  input  logic            d_wr_en,
  input  logic [RA_W-1:0] d_wr_addr,
  input  logic [T_W-1:0]  d_tnew,
  input  logic            d_md_start,
  input  logic            d_md_div,
  input  logic            d_md_use,
  output logic            stall,
  output logic [FS_W-1:0] fwd_rs,
  output logic [FS_W-1:0] fwd_rt,
  output logic            md_busy
);

  localparam int CNT_W = $clog2(DIV_CYC + 1);
  localparam logic [T_W-1:0] TUSE_NONE = {T_W{1'b1}};

  logic [STAGES:1]                v_q, v_d;
  logic [STAGES:1][RA_W-1:0]      addr_q, addr_d;
  logic [STAGES:1][T_W-1:0]       tnew_q, tnew_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;

  logic                           stall_rs, stall_rt;
  logic                           issue;

  // Returns {stall, fwd} for one operand; the descending loop lets the youngest match win.
  function automatic logic [FS_W:0] lookup(input logic [RA_W-1:0] r,
                                           input logic [T_W-1:0]  tuse);
    logic            st;
    logic [FS_W-1:0] fs;
    st = 1'b0;
    fs = '0;
    for (int k = STAGES; k >= 1; k--) begin
      if (v_q[k] && (addr_q[k] == r) && (r != '0)) begin
        st = (tuse != TUSE_NONE) && (tnew_q[k] > tuse);
        fs = (tnew_q[k] == '0) ? FS_W'(k) : '0;
      end
    end
    return {st, fs};
  endfunction

  always_comb begin
    {stall_rs, fwd_rs} = lookup(d_rs, d_tuse_rs);
    {stall_rt, fwd_rt} = lookup(d_rt, d_tuse_rt);
    md_busy = (cnt_q != '0);
    stall   = d_valid && (stall_rs || stall_rt || (d_md_use && md_busy));
    issue   = d_valid && !stall;
  end

  always_comb begin
    v_d       = '0;
    addr_d    = addr_q;
    tnew_d    = tnew_q;
    v_d[1]    = !flush && issue && d_wr_en && (d_wr_addr != '0);
    addr_d[1] = d_wr_addr;
    tnew_d[1] = d_tnew;
    for (int k = 1; k < STAGES; k++) begin
      v_d[k+1]    = !flush && v_q[k];
      addr_d[k+1] = addr_q[k];
      tnew_d[k+1] = (tnew_q[k] == '0) ? '0 : tnew_q[k] - T_W'(1);
    end
  end

  // Flush leaves the counter alone: the issued mult/div keeps executing.
  always_comb begin
    cnt_d = cnt_q;
    if (issue && d_md_start) begin
      cnt_d = d_md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      v_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  // Address/tnew payload is qualified by v_q, so it needs no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    tnew_q <= tnew_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: the driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       d_valid;
  logic [4:0] d_rs, d_rt, d_wr_addr;
  logic [1:0] d_tuse_rs, d_tuse_rt, d_tnew;
  logic       d_wr_en, d_md_start, d_md_div, d_md_use;
  logic       stall, md_busy;
  logic [1:0] fwd_rs, fwd_rt;

  typedef struct {
    string      nm;
    logic       s;
    logic [1:0] fr;
    logic [1:0] ft;
    logic       mb;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  hazard_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .d_valid(d_valid),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew),
    .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
    .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt), .md_busy(md_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Monitor: outputs are valid every cycle; compare at the negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_chk++;
        if (stall !== e.s) begin
          n_err++;
          $display("FAIL %s stall: got %b want %b", e.nm, stall, e.s);
        end
        n_chk++;
        if (fwd_rs !== e.fr) begin
          n_err++;
          $display("FAIL %s fwd_rs: got %0d want %0d", e.nm, fwd_rs, e.fr);
        end
        n_chk++;
        if (fwd_rt !== e.ft) begin
          n_err++;
          $display("FAIL %s fwd_rt: got %0d want %0d", e.nm, fwd_rt, e.ft);
        end
        n_chk++;
        if (md_busy !== e.mb) begin
          n_err++;
          $display("FAIL %s md_busy: got %b want %b", e.nm, md_busy, e.mb);
        end
      end
    end
  end

  task automatic setd(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] urs, input logic [1:0] urt,
                      input logic we, input logic [4:0] wa, input logic [1:0] tn,
                      input logic ms, input logic md, input logic mu);
    d_valid = v; d_rs = rs; d_rt = rt; d_tuse_rs = urs; d_tuse_rt = urt;
    d_wr_en = we; d_wr_addr = wa; d_tnew = tn;
    d_md_start = ms; d_md_div = md; d_md_use = mu;
  endtask

  task automatic idle();
    setd(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Queue the expectation for the current cycle, then advance one clock.
  task automatic cyc(input string nm, input logic s, input logic [1:0] fr,
                     input logic [1:0] ft, input logic mb);
    exp_t e;
    e.nm = nm; e.s = s; e.fr = fr; e.ft = ft; e.mb = mb;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    idle();
    for (int i = 0; i < n; i++) cyc("drain", 1'b0, 2'd0, 2'd0, 1'b0);
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    setd(1'b1, 5'd8, 5'd8, 2'd0, 2'd0, 1'b1, 5'd8, 2'd2, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    cyc("reset_state", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    drain(2);

    // addu $8 (tnew=1) then beq $8 (tuse=0)
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc("addu8", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b1, 5'd8, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc("beq8_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("beq8_fwd_m", 1'b0, 2'd2, 2'd0, 1'b0);
    drain(3);

    // lw $9 (tnew=2) then addu rs=$9 (tuse=1)
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("lw9_a", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b1, 5'd9, 5'd0, 2'd1, 2'd3, 1'b1, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc("addu9_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("addu9_nofwd", 1'b0, 2'd0, 2'd0, 1'b0);
    drain(3);

    // lw $9 then beq $9,$9 (tuse=0 on both operands)
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("lw9_b", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b1, 5'd9, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc("beq9_stall1", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("beq9_stall2", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("beq9_fwd_w", 1'b0, 2'd3, 2'd3, 1'b0);
    drain(3);

    // two writers of $8: youngest (E, tnew=1) governs over M (tnew=0)
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd8, 2'd1, 1'b0, 1'b0, 1'b0);
    cyc("w8_first", 1'b0, 2'd0, 2'd0, 1'b0);
    cyc("w8_second", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b1, 5'd0, 5'd8, 2'd3, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc("youngest_stall", 1'b1, 2'd0, 2'd0, 1'b0);
    cyc("youngest_fwd_m", 1'b0, 2'd0, 2'd2, 1'b0);
    drain(3);

    // writes to $0 are never tracked
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("w0", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b1, 5'd0, 5'd0, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc("beq0", 1'b0, 2'd0, 2'd0, 1'b0);
    drain(2);

    // mult then mfhi: 5 stall cycles, issues on the 6th
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b0, 1'b1);
    cyc("mult", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cyc("mfhi_mult_stall", 1'b1, 2'd0, 2'd0, 1'b1);
    cyc("mfhi_mult_go", 1'b0, 2'd0, 2'd0, 1'b0);
    drain(3);

    // div: 10 busy cycles; a non-valid D slot never stalls
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    cyc("div", 1'b0, 2'd0, 2'd0, 1'b0);
    setd(1'b0, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc("invalid_no_stall", 1'b0, 2'd0, 2'd0, 1'b1);
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd11, 2'd1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) cyc("mfhi_div_stall", 1'b1, 2'd0, 2'd0, 1'b1);
    cyc("mfhi_div_go", 1'b0, 2'd0, 2'd0, 1'b0);
    drain(3);

    // flush clears the lw $9 entry and kills the $10 writer loaded that cycle
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("lw9_c", 1'b0, 2'd0, 2'd0, 1'b0);
    flush = 1'b1;
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd10, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("flush_cycle", 1'b0, 2'd0, 2'd0, 1'b0);
    flush = 1'b0;
    setd(1'b1, 5'd9, 5'd10, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc("after_flush", 1'b0, 2'd0, 2'd0, 1'b0);
    drain(3);

    // reset mid-operation: entry valid and counter at 7
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b0, 5'd0, 2'd0, 1'b1, 1'b1, 1'b1);
    cyc("div_b", 1'b0, 2'd0, 2'd0, 1'b0);
    idle();
    cyc("div_b_cnt10", 1'b0, 2'd0, 2'd0, 1'b1);
    cyc("div_b_cnt9", 1'b0, 2'd0, 2'd0, 1'b1);
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("lw9_d_cnt8", 1'b0, 2'd0, 2'd0, 1'b1);
    reset = 1'b0;
    setd(1'b1, 5'd9, 5'd0, 2'd0, 2'd3, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    cyc("pre_reset_cnt7", 1'b1, 2'd0, 2'd0, 1'b1);
    reset = 1'b1;
    cyc("post_reset", 1'b0, 2'd0, 2'd0, 1'b0);
    drain(3);

    // simultaneous reset and flush
    setd(1'b1, 5'd0, 5'd0, 2'd3, 2'd3, 1'b1, 5'd9, 2'd2, 1'b0, 1'b0, 1'b0);
    cyc("lw9_e", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b0;
    flush = 1'b1;
    idle();
    cyc("rst_and_flush", 1'b0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    flush = 1'b0;
    setd(1'b1, 5'd9, 5'd9, 2'd0, 2'd0, 1'b0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    cyc("after_rst_flush", 1'b0, 2'd0, 2'd0, 1'b0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() > 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised, stateful successor to the per-instruction Tuse/Tnew classifier.
- Takes the decoded D-stage Tuse/Tnew/register fields and tracks every in-flight writer in a STAGES-deep scoreboard.
- Also tracks the busy time of a multi-cycle mult/div unit.
- Produces the D-stage stall and the D-stage forward-source selects for a MIPS pipeline of configurable depth.

Parameters:
- STAGES, 3, post-decode stages tracked (1=E, 2=M, 3=W).
- RA_W, 5, register address width.
- T_W, 2, Tuse/Tnew width; all-ones Tuse means operand unused.
- MULT_CYC, 5, cycles HI/LO stay busy after a mult issues.
- DIV_CYC, 10, cycles HI/LO stay busy after a div issues.
- FS_W, 2, fwd select width, must satisfy 2^FS_W >= STAGES+1.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-low.
- flush in 1: discard all scoreboard entries.
- d_valid in 1: D holds a real instruction.
- d_rs in RA_W: rs field of the D instruction.
- d_rt in RA_W: rt field of the D instruction.
- d_tuse_rs in T_W: Tuse for rs.
- d_tuse_rt in T_W: Tuse for rt.
- d_wr_en in 1: D instruction writes a GPR.
- d_wr_addr in RA_W: destination GPR.
- d_tnew in T_W: Tnew on entry to E.
- d_md_start in 1: D instruction is mult/multu/div/divu.
- d_md_div in 1: that instruction is a div.
- d_md_use in 1: D instruction is mf*/mt*/mult/div (touches HI/LO).
- stall out 1: freeze PC and the F/D register, inject a bubble into E.
- fwd_rs out FS_W: D-stage rs source; 0 = regfile, k = stage k.
- fwd_rt out FS_W: D-stage rt source; same encoding.
- md_busy out 1: mult/div busy counter is nonzero.

Behaviour:
- Scoreboard: STAGES entries {v, addr, tnew}; entry 1 = E ... entry STAGES = W. Shifts every clock; the post-D pipeline never stalls.
- Entry 1 load value:
  - If d_valid && !stall && d_wr_en && d_wr_addr != 0: {1, d_wr_addr, d_tnew}.
  - Otherwise: v=0 (bubble).
- Shift: entry k+1 <= entry k, with tnew decremented and saturating at 0. The last entry falls off.
- Match for operand r (r = rs or rt): v && addr == r && r != 0. The youngest match (lowest k) is authoritative; older matches are ignored.
- Operand stall: a match exists, Tuse != all-ones, and match.tnew > Tuse.
- Forwarding:
  - fwd = k if the youngest match has tnew == 0; otherwise 0.
  - r == 0 or no match: fwd = 0.
  - Match with 0 < tnew <= Tuse: fwd = 0 and no stall; the value is picked up by downstream-stage forwarding.
- MD counter (width clog2(DIV_CYC+1)):
  - On d_valid && !stall && d_md_start: load DIV_CYC if d_md_div, else MULT_CYC.
  - Otherwise decrement while nonzero.
  - md_busy = (cnt != 0).
- stall = d_valid && (stall_rs || stall_rt || (d_md_use && md_busy)). Combinational; d_valid=0 forces stall=0.
- flush: at the clock edge, clears every entry's v and kills the entry 1 load that cycle. The MD counter is unaffected because the issued op is already executing.
- reset (low at edge): all v=0 and counter=0. The same cycle after reset, stall=0, fwd_rs=fwd_rt=0, md_busy=0.
- Reset mid-operation discards all pending hazards and any remaining busy time.
- Simultaneous reset and flush: reset wins; the result is identical.

Test Plan:
- addu $8 (tnew=1) then beq $8 (tuse_rs=0) -> stall=1 for 1 cycle; next cycle fwd_rs=2, stall=0.
- lw $9 (tnew=2) then addu rs=$9 (tuse=1) -> stall 1 cycle; then fwd_rs=0 (match in M, tnew=1 <= tuse), no stall.
- lw $9 then beq $9 (tuse=0) -> stall 2 cycles; third cycle fwd_rs=3, stall=0.
- E:$8 tnew=1, M:$8 tnew=0, beq $8 tuse=0 -> stall=1 (youngest governs); write to $0 with tnew=2 then beq $0 -> stall=0, fwd_rs=0.
- mult issued, then mfhi in D (MULT_CYC=5) -> md_busy high 5 cycles, stall 5 cycles, mfhi issues on cycle 6; div -> 10 cycles.
- lw $9 then flush -> next-cycle beq $9 sees no stall; reset low with entries valid and counter=7 -> after edge stall=0, md_busy=0, fwd=0.
